// File: rtl/cmd_cfg_if.sv
// Command-frame link between the wireless UART wrapper (master) and cmd_cfg (slave).
// Handshake: the master holds cmd_rdy/cmd/data stable until the slave pulses clr_cmd_rdy for one cycle. The slave then pulses send_resp for one cycle and holds resp until its next send_resp. The master pulses resp_sent for one cycle once that byte has been transmitted.
interface cmd_cfg_if;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport master (
        output cmd_rdy, cmd, data, resp_sent,
        input  clr_cmd_rdy, send_resp, resp
    );

    modport slave (
        input  cmd_rdy, cmd, data, resp_sent,
        output clr_cmd_rdy, send_resp, resp
    );
endinterface

// File: rtl/cmd_cfg.sv
// Command decoder for the quadcopter: turns UART frames into flight setpoints,
// runs the motor spin-up / inertial calibration sequence and returns a response byte.
module cmd_cfg #(
    parameter bit         FAST_SIM = 1'b1,
    parameter logic [7:0] ACK      = 8'hA5,
    parameter logic [7:0] NAK      = 8'hEE
) (
    input  logic         clk,
    input  logic         rst,
    cmd_cfg_if.slave     bus,
    input  logic [7:0]   batt,
    input  logic         cal_done,
    output logic [15:0]  d_ptch,
    output logic [15:0]  d_roll,
    output logic [15:0]  d_yaw,
    output logic [8:0]   thrst,
    output logic         strt_cal,
    output logic         inertial_cal,
    output logic         motors_off,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPIN     = 2'd1,
        CAL      = 2'd2,
        WAIT_RSP = 2'd3
    } state_t;

    localparam logic [7:0] OP_REQ_BATT  = 8'h01;
    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [25:0] SPIN_TERM = FAST_SIM ? 26'd511 : 26'h3FF_FFFF;

    state_t      state_q, state_d;
    logic [15:0] d_ptch_q, d_ptch_d;
    logic [15:0] d_roll_q, d_roll_d;
    logic [15:0] d_yaw_q, d_yaw_d;
    logic [8:0]  thrst_q, thrst_d;
    logic [7:0]  resp_q, resp_d;
    logic [25:0] timer_q, timer_d;
    logic        send_resp_q, send_resp_d;
    logic        strt_cal_q, strt_cal_d;
    logic        inertial_cal_q, inertial_cal_d;
    logic        motors_off_q, motors_off_d;
    logic        clr_cmd_rdy;

    always_comb begin
        state_d        = state_q;
        d_ptch_d       = d_ptch_q;
        d_roll_d       = d_roll_q;
        d_yaw_d        = d_yaw_q;
        thrst_d        = thrst_q;
        resp_d         = resp_q;
        timer_d        = timer_q;
        send_resp_d    = 1'b0;
        strt_cal_d     = 1'b0;
        inertial_cal_d = inertial_cal_q;
        motors_off_d   = motors_off_q;
        clr_cmd_rdy    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_rdy && !rst) begin
                    // Frame is consumed in the decode cycle itself; the response follows a cycle later.
                    clr_cmd_rdy = 1'b1;
                    resp_d      = ACK;
                    send_resp_d = 1'b1;
                    state_d     = WAIT_RSP;
                    case (bus.cmd)
                        OP_REQ_BATT:  resp_d   = batt;
                        OP_SET_PTCH:  d_ptch_d = bus.data;
                        OP_SET_ROLL:  d_roll_d = bus.data;
                        OP_SET_YAW:   d_yaw_d  = bus.data;
                        OP_SET_THRST: thrst_d  = bus.data[8:0];
                        OP_EMER_LAND: begin
                            d_ptch_d = 16'd0;
                            d_roll_d = 16'd0;
                            d_yaw_d  = 16'd0;
                            thrst_d  = 9'd0;
                        end
                        OP_MTRS_OFF:  motors_off_d = 1'b1;
                        OP_CALIBRATE: begin
                            resp_d         = resp_q;
                            send_resp_d    = 1'b0;
                            motors_off_d   = 1'b0;
                            inertial_cal_d = 1'b1;
                            timer_d        = 26'd0;
                            state_d        = SPIN;
                        end
                        default:      resp_d = NAK;
                    endcase
                end
            end
            SPIN: begin
                if (timer_q == SPIN_TERM) begin
                    strt_cal_d = 1'b1;
                    state_d    = CAL;
                end else begin
                    timer_d = timer_q + 26'd1;
                end
            end
            CAL: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    resp_d         = ACK;
                    send_resp_d    = 1'b1;
                    state_d        = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.resp_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            d_ptch_q       <= 16'd0;
            d_roll_q       <= 16'd0;
            d_yaw_q        <= 16'd0;
            thrst_q        <= 9'd0;
            resp_q         <= 8'd0;
            timer_q        <= 26'd0;
            send_resp_q    <= 1'b0;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            motors_off_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            d_ptch_q       <= d_ptch_d;
            d_roll_q       <= d_roll_d;
            d_yaw_q        <= d_yaw_d;
            thrst_q        <= thrst_d;
            resp_q         <= resp_d;
            timer_q        <= timer_d;
            send_resp_q    <= send_resp_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
            motors_off_q   <= motors_off_d;
        end
    end

    assign bus.clr_cmd_rdy = clr_cmd_rdy;
    assign bus.send_resp   = send_resp_q;
    assign bus.resp        = resp_q;
    assign d_ptch          = d_ptch_q;
    assign d_roll          = d_roll_q;
    assign d_yaw           = d_yaw_q;
    assign thrst           = thrst_q;
    assign strt_cal        = strt_cal_q;
    assign inertial_cal    = inertial_cal_q;
    assign motors_off      = motors_off_q;
    assign dbg_state       = state_q;

endmodule
